// File: rtl/lif_neuron_if.sv
// Bundle between the layer controller / axon fabric and one LIF neuron:
// weight write port, axon handshake and spike/potential status.
interface lif_neuron_if #(
    parameter int N_INPUTS = 8,
    parameter int WEIGHT_W = 8,
    parameter int POT_W    = 16,
    parameter int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WEIGHT_W-1:0] wr_data;
    logic                axon_valid;
    logic [N_INPUTS-1:0] axon;
    logic                axon_ready;
    logic                spike;
    logic [POT_W-1:0]    potential;
    logic                refract;

    modport master (
        output wr_en, wr_addr, wr_data, axon_valid, axon,
        input  axon_ready, spike, potential, refract
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, axon_valid, axon,
        output axon_ready, spike, potential, refract
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: N weighted synapses accumulated serially,
// signed saturating membrane potential, shift-based leak, refractory period.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for an axon vector; leak applied on acceptance
// S_ACCUM   | adding weight[k] for each set axon bit, one synapse per cycle
// S_FIRE    | one cycle holding the committed result / spike pulse
// S_REFRACT | one cycle consuming a discarded vector, refract count - 1
module lif_neuron #(
    parameter int N_INPUTS      = 8,
    parameter int WEIGHT_W      = 8,
    parameter int POT_W         = 16,
    parameter int THRESHOLD     = 64,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input logic         clk,
    input logic         rst,
    lif_neuron_if.slave bus
);
    localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int RC_W   = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam logic [ADDR_W-1:0]       K_LAST = ADDR_W'(N_INPUTS - 1);
    localparam logic [RC_W-1:0]         RC_INIT = RC_W'(REFRACT_STEPS);
    localparam logic signed [POT_W-1:0] THRESH  = POT_W'(THRESHOLD);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE, S_REFRACT} state_t;

    state_t                     state, state_nx;
    logic signed [WEIGHT_W-1:0] weight [N_INPUTS];
    logic [N_INPUTS-1:0]        axon_q;
    logic [ADDR_W-1:0]          k;
    logic signed [POT_W-1:0]    acc;
    logic signed [POT_W-1:0]    potential;
    logic [RC_W-1:0]            refract_cnt;
    logic                       spike;

    logic signed [WEIGHT_W-1:0] w_k;
    logic signed [POT_W:0]      sum_wide;
    logic signed [POT_W-1:0]    sum_sat;
    logic signed [POT_W-1:0]    acc_add;
    logic signed [POT_W-1:0]    leaked;
    logic                       fire;
    logic                       addr_ok;

    always_comb begin
        w_k      = weight[k];
        sum_wide = {acc[POT_W-1], acc} + {{(POT_W + 1 - WEIGHT_W){w_k[WEIGHT_W-1]}}, w_k};
        // One guard bit is enough: a disagreement with the sign bit means overflow.
        if (sum_wide[POT_W] != sum_wide[POT_W-1])
            sum_sat = sum_wide[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        else
            sum_sat = sum_wide[POT_W-1:0];
        acc_add = axon_q[k] ? sum_sat : acc;
        leaked  = (LEAK_SHIFT == 0) ? potential : potential - (potential >>> LEAK_SHIFT);
        fire    = (acc_add >= THRESH);
        addr_ok = (32'(bus.wr_addr) < 32'(N_INPUTS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.axon_valid) state_nx = (refract_cnt != '0) ? S_REFRACT : S_ACCUM;
            S_ACCUM:   if (k == K_LAST) state_nx = S_FIRE;
            S_FIRE:    state_nx = S_IDLE;
            S_REFRACT: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) weight[i] <= '0;
            axon_q      <= '0;
            k           <= '0;
            acc         <= '0;
            potential   <= '0;
            refract_cnt <= '0;
            spike       <= 1'b0;
        end else begin
            // The read of weight[k] above sees the pre-edge value on a collision.
            if (bus.wr_en && addr_ok) weight[bus.wr_addr] <= bus.wr_data;
            spike <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.axon_valid && refract_cnt == '0) begin
                        axon_q <= bus.axon;
                        acc    <= leaked;
                        k      <= '0;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_add;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        if (fire) begin
                            spike       <= 1'b1;
                            potential   <= '0;
                            refract_cnt <= RC_INIT;
                        end else begin
                            potential <= acc_add;
                        end
                    end
                end
                S_REFRACT: refract_cnt <= refract_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.axon_ready = (state == S_IDLE);
    assign bus.spike      = spike;
    assign bus.potential  = potential;
    assign bus.refract    = (refract_cnt != '0);
endmodule
